// File: rtl/pword_writer.sv
// Password reprogramming FSM: collects a new password, then checks a second
// entry against it, then writes the digits into the password RAM.
module pword_writer #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              reconf,
  input  logic              timeout,
  input  logic [DATA_W-1:0] pword,
  input  logic              pword_enter,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] digit_cnt,
  output logic [3:0]        currentstate
);

  localparam int DIGITS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DIGITS - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_COLLECT = 4'd1,
    S_CONFIRM = 4'd2,
    S_WRITE   = 4'd3,
    S_DONE    = 4'd4,
    S_FAIL    = 4'd5
  } state_t;

  state_t                        state_q, state_d;
  logic [ADDR_W-1:0]             idx_q, idx_d;
  logic [DIGITS-1:0][DATA_W-1:0] buf_q, buf_d;
  logic                          mis_q, mis_d;
  logic                          miss_now;

  logic              wren_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              busy_q, done_q, fail_q;
  logic [ADDR_W-1:0] cnt_q;
  state_t            cs_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    mis_d    = mis_q;
    miss_now = (pword != buf_q[idx_q]);
    case (state_q)
      S_IDLE: begin
        if (reconf) begin
          state_d = S_COLLECT;
          idx_d   = '0;
          mis_d   = 1'b0;
        end
      end
      S_COLLECT: begin
        if (timeout) begin
          state_d = S_FAIL;
          idx_d   = '0;
        end else if (!reconf) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (pword_enter) begin
          buf_d[idx_q] = pword;
          idx_d        = idx_q + ONE;
          if (idx_q == LAST) state_d = S_CONFIRM;
        end
      end
      S_CONFIRM: begin
        if (timeout) begin
          state_d = S_FAIL;
          idx_d   = '0;
        end else if (!reconf) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (pword_enter) begin
          mis_d = mis_q | miss_now;
          idx_d = idx_q + ONE;
          // Decision must see the last digit's own comparison.
          if (idx_q == LAST) begin
            state_d = (mis_q | miss_now) ? S_FAIL : S_WRITE;
          end
        end
      end
      S_WRITE: begin
        idx_d = idx_q + ONE;
        if (idx_q == LAST) state_d = S_DONE;
      end
      S_DONE, S_FAIL: begin
        idx_d = '0;
        if (!reconf) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs are registered from next-state so they line up with state_q.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      mis_q   <= 1'b0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      cnt_q   <= '0;
      cs_q    <= S_IDLE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      mis_q   <= mis_d;
      wren_q  <= (state_d == S_WRITE);
      addr_q  <= (state_d == S_WRITE) ? idx_d : '0;
      data_q  <= (state_d == S_WRITE) ? buf_d[idx_d] : '0;
      busy_q  <= (state_d == S_COLLECT) || (state_d == S_CONFIRM) ||
                 (state_d == S_WRITE);
      done_q  <= (state_d == S_DONE);
      fail_q  <= (state_d == S_FAIL);
      cnt_q   <= idx_d;
      cs_q    <= state_d;
    end
  end

  assign ram_wren     = wren_q;
  assign ram_addr     = addr_q;
  assign ram_data     = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fail         = fail_q;
  assign digit_cnt    = cnt_q;
  assign currentstate = cs_q;

endmodule

// File: tb/tb_pword_writer.sv
// Directed bench for pword_writer: RAM writes go through a scoreboard queue,
// state/flag outputs are checked directly after each step.
module tb_pword_writer;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic              reconf;
  logic              timeout;
  logic [DATA_W-1:0] pword;
  logic              pword_enter;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic              busy;
  logic              done;
  logic              fail;
  logic [ADDR_W-1:0] digit_cnt;
  logic [3:0]        currentstate;

  int n_cmp = 0;
  int n_bad = 0;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0]        ram[4];

  pword_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .RST(RST), .reconf(reconf), .timeout(timeout),
    .pword(pword), .pword_enter(pword_enter),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .busy(busy), .done(done), .fail(fail),
    .digit_cnt(digit_cnt), .currentstate(currentstate)
  );

  always #5 CLK = ~CLK;

  // Monitor: every RAM write must match the next queued expectation.
  always @(negedge CLK) begin
    if (ram_wren) begin
      ram[ram_addr] = ram_data;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d, required none",
                 ram_addr, ram_data);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        if ({ram_addr, ram_data} !== e) begin
          n_bad++;
          $display("FAIL ram_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                   ram_addr, ram_data, e[DATA_W+:ADDR_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic enter(input int d);
    pword       = DATA_W'(d);
    pword_enter = 1'b1;
    tick();
    pword_enter = 1'b0;
  endtask

  task automatic enter4(input int a, input int b, input int c, input int d);
    enter(a); enter(b); enter(c); enter(d);
  endtask

  task automatic push(input int a, input int d);
    exp_q.push_back({ADDR_W'(a), DATA_W'(d)});
  endtask

  task automatic start();
    reconf = 1'b1;
    tick();
    chk("start_collect", currentstate, 1);
  endtask

  initial begin
    RST = 1'b1; reconf = 1'b0; timeout = 1'b0;
    pword = '0; pword_enter = 1'b0;
    for (int i = 0; i < 4; i++) ram[i] = '0;
    tick(); tick();
    chk("rst_state", currentstate, 0);
    chk("rst_wren", ram_wren, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_cnt", digit_cnt, 0);
    RST = 1'b0;
    tick();

    // 1: good program 2709
    start();
    push(0, 2); push(1, 7); push(2, 0); push(3, 9);
    enter4(2, 7, 0, 9);
    chk("t1_confirm", currentstate, 2);
    chk("t1_busy", busy, 1);
    enter4(2, 7, 0, 9);
    chk("t1_write", currentstate, 3);
    tick(); tick(); tick();
    chk("t1_not_done_yet", done, 0);
    tick();
    chk("t1_done", done, 1);
    chk("t1_busy_off", busy, 0);
    chk("t1_state", currentstate, 4);
    chk("t1_ram", {ram[0], ram[1], ram[2], ram[3]}, 16'h2709);
    reconf = 1'b0;
    tick();
    chk("t1_idle", currentstate, 0);

    // 2: confirm mismatch on last digit
    start();
    enter4(3, 1, 5, 3);
    enter4(3, 1, 5, 4);
    chk("t2_fail", fail, 1);
    chk("t2_state", currentstate, 5);
    tick();
    chk("t2_hold", fail, 1);
    reconf = 1'b0;
    tick();
    chk("t2_idle", currentstate, 0);
    chk("t2_fail_off", fail, 0);

    // 3: timeout mid-collect, with a simultaneous enter discarded
    start();
    enter(3); enter(1);
    timeout = 1'b1; pword_enter = 1'b1; pword = 4'd6;
    tick();
    timeout = 1'b0; pword_enter = 1'b0;
    chk("t3_fail", currentstate, 5);
    chk("t3_cnt", digit_cnt, 0);
    reconf = 1'b0;
    tick();
    // reconf dropped instead
    start();
    enter(3); enter(1);
    reconf = 1'b0;
    tick();
    chk("t3b_idle", currentstate, 0);
    chk("t3b_nofail", fail, 0);
    // timeout and reconf drop together in CONFIRM
    start();
    enter4(1, 1, 1, 1);
    enter(1);
    reconf = 1'b0; timeout = 1'b1;
    tick();
    timeout = 1'b0;
    chk("t3c_fail_wins", currentstate, 5);
    tick();
    chk("t3c_idle", currentstate, 0);

    // 4a: aborts ignored during WRITE
    start();
    push(0, 6); push(1, 8); push(2, 1); push(3, 4);
    enter4(6, 8, 1, 4);
    enter4(6, 8, 1, 4);
    tick();
    reconf = 1'b0; timeout = 1'b1;
    tick();
    timeout = 1'b0;
    chk("t4_still_write", currentstate, 3);
    tick(); tick();
    chk("t4_done", currentstate, 4);
    tick();
    chk("t4_idle", currentstate, 0);

    // 4b: reset mid-WRITE
    start();
    push(0, 5); push(1, 10);
    enter4(5, 10, 12, 15);
    enter4(5, 10, 12, 15);
    tick();
    RST = 1'b1; reconf = 1'b0;
    tick();
    chk("t4b_wren", ram_wren, 0);
    chk("t4b_state", currentstate, 0);
    RST = 1'b0;
    tick();

    // 5: back-to-back enters
    start();
    push(0, 1); push(1, 2); push(2, 3); push(3, 4);
    for (int i = 0; i < 8; i++) begin
      chk("t5_cnt", digit_cnt, i % 4);
      enter((i % 4) + 1);
    end
    chk("t5_write", currentstate, 3);
    tick(); tick(); tick(); tick();
    chk("t5_done", currentstate, 4);

    // 6: enters ignored in DONE and IDLE
    enter(9);
    chk("t6_done_hold", currentstate, 4);
    chk("t6_done_cnt", digit_cnt, 0);
    reconf = 1'b0;
    enter(9);
    chk("t6_to_idle", currentstate, 0);
    enter(9);
    chk("t6_idle_hold", currentstate, 0);
    chk("t6_idle_cnt", digit_cnt, 0);

    tick(); tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
